// File: rtl/weight_loader_pkg.sv
// weight_loader_pkg: FSM states and fixed constants shared by the weight stream loader.
package weight_loader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_FETCH, S_WAIT, S_DONE} state_e;
    localparam int TAPS_3X3 = 9;
    localparam int TAPS_1X1 = 1;
    localparam int BEAT_BYTES = 4;
    localparam int MAX_FILT = 16;
endpackage

// File: rtl/weight_stream_loader_if.sv
// weight_stream_loader_if: DMA read stream in, DMA request and SRAM write port out.
interface weight_stream_loader_if #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int BITS_TRANS = 18,
    parameter int WEIGHT_SRAM_ADDRESS = 8,
    parameter int DOUT_WIDTH = 1152
);
    logic [AXI_WIDTH_DA-1:0] data_o;
    logic data_vld_o;
    logic [BITS_TRANS-1:0] data_cnt_o;
    logic done_o;
    logic start_dma;
    logic [BITS_TRANS-1:0] num_trans;
    logic [AXI_WIDTH_AD-1:0] start_addr;
    logic w_en;
    logic [WEIGHT_SRAM_ADDRESS-1:0] w_addr;
    logic [DOUT_WIDTH-1:0] w_data;
    modport master (
        input data_o, data_vld_o, data_cnt_o, done_o,
        output start_dma, num_trans, start_addr, w_en, w_addr, w_data
    );
    modport slave (
        output data_o, data_vld_o, data_cnt_o, done_o,
        input start_dma, num_trans, start_addr, w_en, w_addr, w_data
    );
endinterface

// File: rtl/weight_word_packer.sv
// weight_word_packer: packs beats into a zero-padded word; last_o flags the completing beat.
module weight_word_packer #(
    parameter int DW = 1152,
    parameter int BW = 32,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic rstn,
    input  logic [BW-1:0] beat_i,
    input  logic valid_i,
    input  logic [CNT_W-1:0] bpw_i,
    input  logic clear_i,
    output logic last_o,
    output logic word_valid_o,
    output logic [DW-1:0] word_o
);
    localparam int IW = $clog2(DW);
    logic [DW-1:0] acc_q, acc_d, word_q;
    logic [CNT_W-1:0] cnt_q;
    logic vld_q;
    logic [IW-1:0] lsb;
    assign lsb = IW'(BW * int'(cnt_q));
    assign last_o = valid_i && (cnt_q + CNT_W'(1) == bpw_i);
    assign word_valid_o = vld_q;
    assign word_o = word_q;
    always_comb begin
        acc_d = acc_q;
        acc_d[lsb +: BW] = beat_i;
    end
    // The accumulator is cleared after every word so unused beats stay zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
            word_q <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else if (clear_i) begin
            acc_q <= '0;
            word_q <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= last_o;
            word_q <= last_o ? acc_d : '0;
            if (valid_i) begin
                acc_q <= last_o ? '0 : acc_d;
                cnt_q <= last_o ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/weight_stream_loader.sv
// weight_stream_loader: fetches a multi-filter weight burst via DMA and packs it into SRAM words.
module weight_stream_loader
    import weight_loader_pkg::*;
#(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int BITS_TRANS = 18,
    parameter int WEIGHT_SRAM_ADDRESS = 8,
    parameter int CALC_CH_W = 16,
    parameter int KMAX = 9,
    parameter int DOUT_WIDTH = KMAX * CALC_CH_W * 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic ap_start,
    output logic ap_done,
    output logic ap_busy,
    output logic ap_err,
    input  logic ksize_1x1,
    input  logic [9:0] in_ch,
    input  logic [4:0] num_filt,
    input  logic [9:0] weight_idx,
    input  logic [AXI_WIDTH_AD-1:0] weight_start_addr,
    weight_stream_loader_if.master bus
);
    localparam int CW_LG = $clog2(CALC_CH_W);
    localparam int GW = 11 - CW_LG;
    localparam int NW = GW + 5;
    localparam int BPW_W = $clog2(KMAX * CALC_CH_W / BEAT_BYTES + 1);
    state_e state_q, state_d;
    logic ksize_q, err_q, err_d, ap_done_q;
    logic [CW_LG-1:0] rem_q;
    logic [GW-1:0] grps_q, grp_q, grps_in;
    logic [NW-1:0] words_q, wcnt_q;
    logic [BITS_TRANS-1:0] num_trans_q;
    logic [AXI_WIDTH_AD-1:0] start_addr_q;
    logic [WEIGHT_SRAM_ADDRESS-1:0] waddr_q;
    logic [31:0] taps_in;
    logic [BPW_W-1:0] bpw;
    logic accept, illegal, fire, last_word, last_grp, unused_cnt;
    assign unused_cnt = ^bus.data_cnt_o;
    assign grps_in = GW'((11'(in_ch) + 11'(CALC_CH_W - 1)) >> CW_LG);
    assign taps_in = ksize_1x1 ? TAPS_1X1 : TAPS_3X3;
    assign illegal = in_ch == '0 || in_ch[1:0] != 2'b00 || num_filt == '0 || 32'(num_filt) > MAX_FILT
                     || 32'(num_filt) * 32'(grps_in) > (32'd1 << WEIGHT_SRAM_ADDRESS);
    assign accept = state_q == S_IDLE && ap_start;
    assign last_word = wcnt_q == words_q - 1'b1;
    assign last_grp = grp_q == grps_q - 1'b1;
    // A partial last group carries only rem channels' worth of beats.
    assign bpw = (last_grp && rem_q != '0)
               ? (ksize_q ? BPW_W'(rem_q >> 2) : BPW_W'(TAPS_3X3 * 32'(rem_q >> 2)))
               : (ksize_q ? BPW_W'(CALC_CH_W / BEAT_BYTES) : BPW_W'(TAPS_3X3 * CALC_CH_W / BEAT_BYTES));
    assign ap_busy = state_q != S_IDLE;
    assign ap_done = ap_done_q;
    assign ap_err = err_q;
    assign bus.start_dma = state_q == S_REQ;
    assign bus.num_trans = num_trans_q;
    assign bus.start_addr = start_addr_q;
    assign bus.w_addr = waddr_q;
    weight_word_packer #(.DW(DOUT_WIDTH), .BW(AXI_WIDTH_DA), .CNT_W(BPW_W)) u_packer (
        .clk(clk),
        .rstn(rstn),
        .beat_i(bus.data_o),
        .valid_i(state_q == S_FETCH && bus.data_vld_o),
        .bpw_i(bpw),
        .clear_i(accept),
        .last_o(fire),
        .word_valid_o(bus.w_en),
        .word_o(bus.w_data)
    );
    always_comb begin
        state_d = state_q;
        err_d = err_q;
        case (state_q)
            S_IDLE: if (ap_start) begin
                state_d = illegal ? S_DONE : S_REQ;
                err_d = illegal;
            end
            S_REQ: state_d = S_FETCH;
            S_FETCH: if (fire && last_word) state_d = bus.done_o ? S_DONE : S_WAIT;
                     else if (bus.done_o) begin
                         state_d = S_DONE;
                         err_d = 1'b1;
                     end
            S_WAIT: if (bus.done_o) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            err_q <= 1'b0;
            ap_done_q <= 1'b0;
            ksize_q <= 1'b0;
            rem_q <= '0;
            grps_q <= '0;
            grp_q <= '0;
            words_q <= '0;
            wcnt_q <= '0;
            waddr_q <= '0;
            num_trans_q <= '0;
            start_addr_q <= '0;
        end else begin
            state_q <= state_d;
            err_q <= err_d;
            ap_done_q <= state_q == S_DONE;
            waddr_q <= fire ? wcnt_q[WEIGHT_SRAM_ADDRESS-1:0] : '0;
            if (accept) begin
                ksize_q <= ksize_1x1;
                rem_q <= in_ch[CW_LG-1:0];
                grps_q <= grps_in;
                words_q <= NW'(32'(num_filt) * 32'(grps_in));
                grp_q <= '0;
                wcnt_q <= '0;
            end else if (fire) begin
                grp_q <= last_grp ? '0 : grp_q + 1'b1;
                wcnt_q <= wcnt_q + 1'b1;
            end
            if (accept && !illegal) begin
                num_trans_q <= BITS_TRANS'((32'(num_filt) * taps_in * 32'(in_ch)) >> 2);
                start_addr_q <= AXI_WIDTH_AD'(32'(weight_start_addr) + 32'(weight_idx) * taps_in * 32'(in_ch));
            end
        end
    end
endmodule

// File: tb/tb_weight_stream_loader.sv
// tb_weight_stream_loader: random loads checked against a byte-level model of the DRAM weight layout.
module tb_weight_stream_loader;
    localparam int DW = 1152;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic ap_start = 1'b0;
    logic ksize_1x1 = 1'b0;
    logic [9:0] in_ch = '0;
    logic [9:0] weight_idx = '0;
    logic [4:0] num_filt = '0;
    logic [31:0] weight_start_addr = '0;
    logic ap_done, ap_busy, ap_err;
    int checks = 0;
    int errors = 0;
    logic [7:0] waddr_q[$];
    logic [DW-1:0] wdata_q[$];
    weight_stream_loader_if bus ();
    weight_stream_loader dut (
        .clk(clk), .rstn(rstn), .ap_start(ap_start), .ap_done(ap_done), .ap_busy(ap_busy), .ap_err(ap_err),
        .ksize_1x1(ksize_1x1), .in_ch(in_ch), .num_filt(num_filt), .weight_idx(weight_idx),
        .weight_start_addr(weight_start_addr), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (bus.w_en === 1'b1) begin
            waddr_q.push_back(bus.w_addr);
            wdata_q.push_back(bus.w_data);
        end else check("w_idle", 64'(|{bus.w_addr, bus.w_data}), 64'd0);
    end
    task automatic run_load(input bit ks, input int inch, input int nf, input int idx, input logic [31:0] base,
                            input int stop_at, input bit late, input bit poke);
        int taps, grps, nt, nbeats, pos, nb, wi, waited, lane;
        logic [31:0] sa;
        bit early;
        logic [7:0] mem[$];
        logic [DW-1:0] w;
        taps = ks ? 1 : 9;
        grps = (inch + 15) / 16;
        nt = nf * taps * inch / 4;
        sa = base + 32'(idx * taps * inch);
        early = stop_at >= 0 && stop_at < nt;
        nbeats = early ? stop_at : nt;
        for (int i = 0; i < nt * 4; i++) mem.push_back(8'($urandom));
        @(negedge clk);
        waddr_q.delete();
        wdata_q.delete();
        ksize_1x1 = ks; in_ch = 10'(inch); num_filt = 5'(nf); weight_idx = 10'(idx); weight_start_addr = base;
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        ksize_1x1 = ~ks; in_ch = 10'(inch + 4); num_filt = 5'(nf + 1); weight_idx = 10'(idx + 1); weight_start_addr = ~base;
        check("start_dma", 64'(bus.start_dma), 64'd1);
        check("num_trans", 64'(bus.num_trans), 64'(nt));
        check("start_addr", 64'(bus.start_addr), 64'(sa));
        check("err_clr", 64'(ap_err), 64'd0);
        @(negedge clk);
        check("dma_pulse", 64'(bus.start_dma), 64'd0);
        check("busy", 64'(ap_busy), 64'd1);
        for (int i = 0; i < nbeats; i++) begin
            bus.data_o = {mem[4*i+3], mem[4*i+2], mem[4*i+1], mem[4*i]};
            bus.data_vld_o = 1'b1;
            bus.done_o = !late && !early && i == nbeats - 1;
            ap_start = poke && i == 3;
            @(negedge clk);
            bus.data_vld_o = 1'b0; bus.done_o = 1'b0; ap_start = 1'b0;
            if (i < nbeats - 1) repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        if (early || late) begin
            if (late) begin
                repeat (2) begin
                    bus.data_o = $urandom; bus.data_vld_o = 1'b1;
                    @(negedge clk);
                end
                bus.data_vld_o = 1'b0;
                check("wait_busy", 64'(ap_busy), 64'd1);
            end
            bus.done_o = 1'b1;
            @(negedge clk);
            bus.done_o = 1'b0;
        end
        waited = 0;
        while (ap_done !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ap_done", 64'(ap_done), 64'd1);
        check("ap_err", 64'(ap_err), 64'(early));
        check("nt_hold", 64'(bus.num_trans), 64'(nt));
        @(negedge clk);
        check("done_pulse", 64'(ap_done), 64'd0);
        check("idle", 64'(ap_busy), 64'd0);
        pos = 0;
        wi = 0;
        for (int f = 0; f < nf; f++) begin
            for (int g = 0; g < grps; g++) begin
                nb = taps * ((g == grps - 1 && inch % 16 != 0) ? inch % 16 : 16);
                if (pos + nb <= nbeats * 4) begin
                    w = '0;
                    for (int j = 0; j < nb; j++) w[8*j +: 8] = mem[pos + j];
                    if (wi < waddr_q.size()) begin
                        check("w_addr", 64'(waddr_q[wi]), 64'(wi));
                        lane = 0;
                        for (int k = DW / 32 - 1; k >= 0; k--) if (wdata_q[wi][32*k +: 32] !== w[32*k +: 32]) lane = k;
                        check($sformatf("w_data[%0d].lane%0d", wi, lane), 64'(wdata_q[wi][32*lane +: 32]), 64'(w[32*lane +: 32]));
                        if (ks) check("hi_zero", 64'(|(wdata_q[wi] >> 128)), 64'd0);
                    end
                    wi++;
                end
                pos += nb;
            end
        end
        check("n_writes", 64'(waddr_q.size()), 64'(wi));
    endtask
    task automatic run_illegal(input int inch, input int nf);
        bit seen;
        @(negedge clk);
        ksize_1x1 = 1'b0; in_ch = 10'(inch); num_filt = 5'(nf); ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        seen = bus.start_dma;
        check("ill_done_t1", 64'(ap_done), 64'd0);
        @(negedge clk);
        seen |= bus.start_dma;
        check("ill_done_t2", 64'(ap_done), 64'd1);
        check("ill_err", 64'(ap_err), 64'd1);
        repeat (3) begin
            @(negedge clk);
            seen |= bus.start_dma;
        end
        check("ill_dma", 64'(seen), 64'd0);
        check("err_hold", 64'(ap_err), 64'd1);
    endtask
    initial begin
        bus.data_o = '0; bus.data_vld_o = 1'b0; bus.data_cnt_o = '0; bus.done_o = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done", 64'(ap_done), 64'd0);
        check("rst_busy", 64'(ap_busy), 64'd0);
        check("rst_err", 64'(ap_err), 64'd0);
        check("rst_dma", 64'(bus.start_dma), 64'd0);
        check("rst_nt", 64'(bus.num_trans), 64'd0);
        check("rst_sa", 64'(bus.start_addr), 64'd0);
        check("rst_wen", 64'(bus.w_en), 64'd0);
        rstn = 1'b1;
        run_load(1'b0, 32, 1, 2, 32'h1000, -1, 1'b0, 1'b1);
        run_load(1'b1, 64, 4, 5, 32'h8000_0000, -1, 1'b1, 1'b0);
        run_load(1'b0, 20, 2, 7, 32'h40, -1, 1'b0, 1'b0);
        run_load(1'b0, 32, 1, 0, 32'h100, 50, 1'b0, 1'b0);
        run_load(1'b1, 20, 3, 1, 32'h0, -1, 1'b0, 1'b0);
        run_load(1'b1, 256, 16, 0, 32'hFFFF_FF00, -1, 1'b1, 1'b0);
        run_illegal(18, 1);
        run_illegal(32, 0);
        run_illegal(32, 17);
        run_illegal(260, 16);
        run_illegal(0, 1);
        for (int r = 0; r < 6; r++)
            run_load(1'($urandom), 4 * $urandom_range(1, 40), $urandom_range(1, 4), $urandom_range(0, 1023), $urandom, -1, 1'($urandom), 1'b0);
        @(negedge clk);
        ksize_1x1 = 1'b0; in_ch = 10'd32; num_filt = 5'd1; weight_idx = '0; weight_start_addr = 32'h2000; ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            bus.data_o = $urandom; bus.data_vld_o = 1'b1;
            @(negedge clk);
        end
        rstn = 1'b0;
        #1;
        check("mid_busy", 64'(ap_busy), 64'd0);
        check("mid_nt", 64'(bus.num_trans), 64'd0);
        check("mid_sa", 64'(bus.start_addr), 64'd0);
        check("mid_out", 64'(|{ap_done, ap_err, bus.start_dma, bus.w_en, bus.w_addr, bus.w_data}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        bus.data_vld_o = 1'b0;
        check("post_rst_idle", 64'(ap_busy), 64'd0);
        run_load(1'b0, 36, 2, 3, 32'h3000, -1, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
